// File: rtl/ps2_pad_resp_pkg.sv
// Shared types and constants for the PS2 pad responder; no logic, no latency.
// The response-byte helper maps a byte index of a poll frame to the pad's answer.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_ACK,
      ST_IGNORE
   } ps2_state_t;

   localparam logic [7:0] PS2_CMD_HDR  = 8'h01;
   localparam logic [7:0] PS2_CMD_POLL = 8'h42;
   localparam logic [7:0] PS2_ID_DIG   = 8'h41;
   localparam logic [7:0] PS2_ID_ANA   = 8'h73;
   localparam logic [7:0] PS2_READY    = 8'h5A;
   localparam logic [7:0] PS2_FILL     = 8'hFF;
   localparam logic [3:0] PS2_LEN_DIG  = 4'd5;
   localparam logic [3:0] PS2_LEN_ANA  = 4'd9;

   function automatic logic [7:0] ps2_resp_byte(input logic [3:0]  idx,
                                                input logic        ana,
                                                input logic [15:0] btn,
                                                input logic [31:0] pss);
      logic [7:0] r;
      r = PS2_FILL;
      case (idx)
         4'd0:    r = PS2_FILL;
         4'd1:    r = ana ? PS2_ID_ANA : PS2_ID_DIG;
         4'd2:    r = PS2_READY;
         4'd3:    r = ~btn[15:8];
         4'd4:    r = ~btn[7:0];
         4'd5:    r = pss[31:24];
         4'd6:    r = pss[23:16];
         4'd7:    r = pss[15:8];
         4'd8:    r = pss[7:0];
         default: r = PS2_FILL;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_pad_resp_sync_edge.sv
// N-flop synchronizer with registered rise/fall strobes; strobes lag the pin by STAGES+1 cycles.
// No backpressure: strobes are single-cycle and must be consumed when they appear.
module ps2_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   // The chain is deliberately not reset: a reset taken while a pin is low
   // must not fabricate an edge once it releases.
   always_ff @(posedge clk) begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
   end

   assign dout = chain[STAGES-1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= dout & ~prev;
         fall <= ~dout & prev;
      end
   end

endmodule

// File: rtl/ps2_pad_resp.sv
// PS2 pad responder: answers host poll frames on miso, acks each byte, captures motor bytes.
// miso moves 1 cycle after a detected sclk fall; ack_n falls ACK_DLY cycles after the 8th rise; no backpressure.
module ps2_pad_resp
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ACK_DLY     = 8,
   parameter int ACK_LEN     = 4
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        scs,
   input  logic        sclk,
   input  logic        smosi,
   input  logic [15:0] buttons,
   input  logic        analog_mode,
   input  logic [31:0] pss,
   output logic        miso,
   output logic        ack_n,
   output logic [7:0]  motor_small,
   output logic [7:0]  motor_large,
   output logic        frame_done,
   output logic        cmd_err
);

   localparam logic [7:0] ACK_ON  = 8'(ACK_DLY - 1);
   localparam logic [7:0] ACK_OFF = 8'(ACK_DLY + ACK_LEN - 2);
   localparam logic [7:0] ACK_END = 8'(ACK_DLY + ACK_LEN - 1);

   ps2_state_t  state, state_nxt;
   logic        scs_s, scs_rise, scs_fall;
   logic        sclk_s, sclk_rise, sclk_fall;
   logic        smosi_s, smosi_rise, smosi_fall;
   logic        unused;

   logic [15:0] snap_btn;
   logic [31:0] snap_pss;
   logic        snap_ana;
   logic [3:0]  byte_idx;
   logic [2:0]  bit_idx;
   logic [7:0]  cmd_sr, cmd_new;
   logic [7:0]  resp_byte, resp0, resp_next;
   logic [7:0]  ack_cnt;
   logic [7:0]  pend_small, pend_large;
   logic [3:0]  last_idx;
   logic        byte_end, hdr_bad, ack_end;
   logic        start, next_byte, err_evt, done_evt, ack_lo, miso_nxt;

   ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_scs (
      .clk(sys_clk), .rst(rst), .din(scs), .dout(scs_s), .rise(scs_rise), .fall(scs_fall));
   ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(sys_clk), .rst(rst), .din(sclk), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
   ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_smosi (
      .clk(sys_clk), .rst(rst), .din(smosi), .dout(smosi_s), .rise(smosi_rise), .fall(smosi_fall));

   assign unused = &{1'b0, scs_rise, sclk_s, smosi_rise, smosi_fall};

   // Command bits arrive LSB first, so the newest bit enters at the top.
   assign cmd_new   = {smosi_s, cmd_sr[7:1]};
   assign last_idx  = snap_ana ? (PS2_LEN_ANA - 4'd1) : (PS2_LEN_DIG - 4'd1);
   assign byte_end  = (state == ST_SHIFT) && sclk_rise && (bit_idx == 3'd7);
   assign hdr_bad   = ((byte_idx == 4'd0) && (cmd_new != PS2_CMD_HDR)) ||
                      ((byte_idx == 4'd1) && (cmd_new != PS2_CMD_POLL));
   assign ack_end   = (state == ST_ACK) && (ack_cnt == ACK_END);
   assign resp0     = ps2_resp_byte(4'd0, analog_mode, buttons, pss);
   assign resp_next = ps2_resp_byte(byte_idx + 4'd1, snap_ana, snap_btn, snap_pss);

   always_ff @(posedge sys_clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (scs_s) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (scs_fall) state_nxt = ST_SHIFT;
            ST_SHIFT:  if (byte_end) state_nxt = (hdr_bad || byte_idx == last_idx) ? ST_IGNORE : ST_ACK;
            ST_ACK:    if (ack_end)  state_nxt = ST_SHIFT;
            ST_IGNORE: state_nxt = ST_IGNORE;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      start     = (state == ST_IDLE) && (state_nxt == ST_SHIFT);
      next_byte = (state == ST_ACK) && (state_nxt == ST_SHIFT);
      err_evt   = byte_end && !scs_s && hdr_bad;
      done_evt  = byte_end && !scs_s && !hdr_bad && (byte_idx == last_idx);
      // ack_n is registered, so the window is evaluated one count early.
      ack_lo    = (state == ST_ACK) && (state_nxt == ST_ACK) &&
                  (ack_cnt >= ACK_ON) && (ack_cnt <= ACK_OFF);
      miso_nxt  = miso;
      if (state_nxt == ST_IDLE || state_nxt == ST_IGNORE)
         miso_nxt = 1'b1;
      else if (start)
         miso_nxt = resp0[0];
      else if (next_byte)
         miso_nxt = resp_next[0];
      else if (state == ST_SHIFT && sclk_fall)
         miso_nxt = resp_byte[bit_idx];
   end

   always_ff @(posedge sys_clk) begin
      if (!rst) begin
         miso        <= 1'b1;
         ack_n       <= 1'b1;
         motor_small <= 8'h00;
         motor_large <= 8'h00;
         frame_done  <= 1'b0;
         cmd_err     <= 1'b0;
         snap_btn    <= 16'h0000;
         snap_pss    <= 32'h0000_0000;
         snap_ana    <= 1'b0;
         byte_idx    <= 4'd0;
         bit_idx     <= 3'd0;
         cmd_sr      <= 8'h00;
         resp_byte   <= PS2_FILL;
         ack_cnt     <= 8'h00;
         pend_small  <= 8'h00;
         pend_large  <= 8'h00;
      end else begin
         miso       <= miso_nxt;
         ack_n      <= ~ack_lo;
         frame_done <= done_evt;
         cmd_err    <= err_evt;
         ack_cnt    <= (state == ST_ACK) ? ack_cnt + 8'd1 : 8'h00;
         if (start) begin
            snap_btn   <= buttons;
            snap_pss   <= pss;
            snap_ana   <= analog_mode;
            byte_idx   <= 4'd0;
            bit_idx    <= 3'd0;
            resp_byte  <= resp0;
            pend_small <= motor_small;
            pend_large <= motor_large;
         end
         if (state == ST_SHIFT && sclk_rise && !scs_s) begin
            cmd_sr  <= cmd_new;
            bit_idx <= bit_idx + 3'd1;
         end
         if (byte_end && !scs_s) begin
            if (byte_idx == 4'd3) pend_small <= cmd_new;
            if (byte_idx == 4'd4) pend_large <= cmd_new;
         end
         if (done_evt) begin
            motor_small <= pend_small;
            motor_large <= (byte_idx == 4'd4) ? cmd_new : pend_large;
         end
         if (next_byte) begin
            byte_idx  <= byte_idx + 4'd1;
            resp_byte <= resp_next;
         end
      end
   end

endmodule

// File: tb/tb_ps2_pad_resp.sv
// Directed bench for ps2_pad_resp: table of whole poll frames plus hand-written abort/reset/ack-timing sequences.
module tb_ps2_pad_resp;

   logic        sys_clk = 1'b0;
   logic        rst;
   logic        scs, sclk, smosi;
   logic [15:0] buttons;
   logic        analog_mode;
   logic [31:0] pss;
   logic        miso, ack_n;
   logic [7:0]  motor_small, motor_large;
   logic        frame_done, cmd_err;

   always #5 sys_clk = ~sys_clk;

   ps2_pad_resp dut (
      .sys_clk(sys_clk), .rst(rst), .scs(scs), .sclk(sclk), .smosi(smosi),
      .buttons(buttons), .analog_mode(analog_mode), .pss(pss),
      .miso(miso), .ack_n(ack_n), .motor_small(motor_small), .motor_large(motor_large),
      .frame_done(frame_done), .cmd_err(cmd_err));

   int   n_vec = 0, n_bad = 0;
   int   n_ack = 0, n_done = 0, n_cerr = 0;
   int   ack_lat = 0, ack_len = 0;
   logic ack_prev = 1'b1;

   always @(posedge sys_clk) begin
      if (ack_prev && !ack_n) n_ack++;
      ack_prev = ack_n;
      if (frame_done === 1'b1) n_done++;
      if (cmd_err === 1'b1) n_cerr++;
   end

   typedef struct {
      logic        ana;
      logic [15:0] btn;
      logic [31:0] pss;
      logic [71:0] cmd;   // byte 0 in bits [7:0]
      logic [71:0] rsp;
      int          nreq;
      int          nrx;
      int          acks;
      int          done;
      int          err;
      logic [7:0]  m_s;
      logic [7:0]  m_l;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Host side of one frame; abort_bits>0 truncates the last requested byte,
   // rst_byte>=0 pulses rst for one cycle after bit 4 of that byte.
   task automatic run_frame(input logic [71:0] cmd, input int nreq, input int abort_bits,
                            input int rst_byte, output logic [71:0] got, output int nrx,
                            output logic miso_end);
      got = '1;
      nrx = 0;
      scs = 1'b0;
      repeat (20) @(negedge sys_clk);
      buttons = ~buttons;
      pss     = ~pss;
      for (int b = 0; b < nreq; b++) begin
         int nb;
         int k;
         nb = (abort_bits > 0 && b == nreq - 1) ? abort_bits : 8;
         for (int i = 0; i < nb; i++) begin
            sclk  = 1'b0;
            smosi = cmd[8*b+i];
            repeat (10) @(negedge sys_clk);
            got[8*b+i] = miso;
            sclk = 1'b1;
            if (b == rst_byte && i == 4) begin
               rst = 1'b0;
               @(negedge sys_clk);
               rst = 1'b1;
               check("rst mid miso", 32'(miso), 32'h1);
               check("rst mid ack_n", 32'(ack_n), 32'h1);
               check("rst mid motor_small", 32'(motor_small), 32'h0);
               check("rst mid motor_large", 32'(motor_large), 32'h0);
            end
            if (i < 7) repeat (10) @(negedge sys_clk);
         end
         nrx = b + 1;
         if (nb < 8) break;
         if (b == nreq - 1) begin
            repeat (10) @(negedge sys_clk);
         end else begin
            k = 0;
            while (ack_n && k < 40) begin
               @(negedge sys_clk);
               k++;
            end
            if (ack_n) break;
            if (b == 0) ack_lat = k;
            k = 0;
            while (!ack_n && k < 20) begin
               @(negedge sys_clk);
               k++;
            end
            if (b == 0) ack_len = k;
         end
      end
      miso_end = miso;
      scs = 1'b1;
      repeat (20) @(negedge sys_clk);
   endtask

   task automatic apply_vec(input int i);
      logic [71:0] got;
      int          nrx, a0, d0, e0;
      logic        me;
      analog_mode = vecs[i].ana;
      buttons     = vecs[i].btn;
      pss         = vecs[i].pss;
      a0 = n_ack; d0 = n_done; e0 = n_cerr;
      run_frame(vecs[i].cmd, vecs[i].nreq, 0, -1, got, nrx, me);
      check($sformatf("v%0d bytes", i), nrx, vecs[i].nrx);
      for (int b = 0; b < vecs[i].nrx; b++)
         check($sformatf("v%0d rsp[%0d]", i, b), 32'(got[8*b+:8]), 32'(vecs[i].rsp[8*b+:8]));
      check($sformatf("v%0d acks", i), n_ack - a0, vecs[i].acks);
      check($sformatf("v%0d frame_done", i), n_done - d0, vecs[i].done);
      check($sformatf("v%0d cmd_err", i), n_cerr - e0, vecs[i].err);
      check($sformatf("v%0d motor_small", i), 32'(motor_small), 32'(vecs[i].m_s));
      check($sformatf("v%0d motor_large", i), 32'(motor_large), 32'(vecs[i].m_l));
      check($sformatf("v%0d miso end", i), 32'(me), 32'h1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [71:0] got;
      int          nrx, a0, d0;
      logic        me;

      vecs[0] = '{1'b0, 16'h8001, 32'h0, 72'h00_00_00_00_00_00_00_42_01,
                  72'h00_00_00_00_FE_7F_5A_41_FF, 5, 5, 4, 1, 0, 8'h00, 8'h00};
      vecs[1] = '{1'b1, 16'h0000, 32'h00FF8040, 72'h00_00_00_00_00_00_00_42_01,
                  72'h40_80_FF_00_FF_FF_5A_73_FF, 9, 9, 8, 1, 0, 8'h00, 8'h00};
      vecs[2] = '{1'b0, 16'h1234, 32'h0, 72'h00_00_00_00_C0_01_00_42_01,
                  72'h00_00_00_00_CB_ED_5A_41_FF, 5, 5, 4, 1, 0, 8'h01, 8'hC0};
      vecs[3] = '{1'b0, 16'h0000, 32'h0, 72'h00_00_00_00_00_00_00_42_03,
                  72'h00_00_00_00_00_00_00_00_FF, 5, 1, 0, 0, 1, 8'h01, 8'hC0};
      vecs[4] = '{1'b1, 16'hFFFF, 32'h11223344, 72'h00_00_00_00_A5_5A_00_42_01,
                  72'h44_33_22_11_00_00_5A_73_FF, 9, 9, 8, 1, 0, 8'h5A, 8'hA5};
      vecs[5] = '{1'b0, 16'h0000, 32'h0, 72'h00_00_00_00_00_00_00_43_01,
                  72'h00_00_00_00_00_00_00_41_FF, 5, 2, 1, 0, 1, 8'h5A, 8'hA5};

      rst = 1'b0; scs = 1'b1; sclk = 1'b1; smosi = 1'b1;
      buttons = 16'h0; analog_mode = 1'b0; pss = 32'h0;
      repeat (5) @(negedge sys_clk);
      rst = 1'b1;
      repeat (5) @(negedge sys_clk);
      check("reset miso", 32'(miso), 32'h1);
      check("reset ack_n", 32'(ack_n), 32'h1);
      check("reset motor_small", 32'(motor_small), 32'h0);
      check("reset motor_large", 32'(motor_large), 32'h0);
      check("reset frame_done", 32'(frame_done), 32'h0);
      check("reset cmd_err", 32'(cmd_err), 32'h0);

      for (int i = 0; i < 6; i++) apply_vec(i);

      // scs raised after 3 bits of byte 3
      analog_mode = 1'b0; buttons = 16'h0; pss = 32'h0;
      a0 = n_ack; d0 = n_done;
      run_frame(72'h00_00_00_00_00_FF_00_42_01, 4, 3, -1, got, nrx, me);
      check("abort rsp[1]", 32'(got[15:8]), 32'h41);
      check("abort acks", n_ack - a0, 3);
      check("abort frame_done", n_done - d0, 0);
      check("abort miso", 32'(miso), 32'h1);
      check("abort ack_n", 32'(ack_n), 32'h1);
      check("abort motor_small", 32'(motor_small), 32'h5A);
      check("abort motor_large", 32'(motor_large), 32'hA5);

      // one-cycle reset in the middle of byte 2
      a0 = n_ack; d0 = n_done;
      run_frame(72'h00_00_00_00_77_66_00_42_01, 5, 0, 2, got, nrx, me);
      check("rst bytes", nrx, 3);
      check("rst rsp[2]", 32'(got[23:16]), 32'hFA);
      check("rst acks", n_ack - a0, 2);
      check("rst frame_done", n_done - d0, 0);
      check("rst motor_small after", 32'(motor_small), 32'h0);

      apply_vec(2);
      check("ack latency", ack_lat, 12);
      check("ack length", ack_len, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
